// File: rtl/fb_pkg.sv
// Shared types and address helper for the frame-buffer port scheduler.
package fb_pkg;

    localparam int unsigned FB_ADDR_W  = 16;
    localparam int unsigned FB_DATA_W  = 24;
    localparam int unsigned FB_COORD_W = 12;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef struct packed {
        logic valid;
        logic in_win;
        logic stolen;
    } fb_tag_t;

    typedef struct packed {
        logic                 in_win;
        logic [FB_ADDR_W-1:0] addr;
    } fb_loc_t;

    // Window test plus linear address (17-bit product truncated to the RAM width).
    function automatic fb_loc_t fb_addr(input logic [FB_COORD_W-1:0] x,
                                        input logic [FB_COORD_W-1:0] y,
                                        input int unsigned h_res,
                                        input int unsigned v_res,
                                        input int unsigned y_off);
        fb_loc_t loc;
        loc.in_win = (32'(x) < h_res) && (32'(y) >= y_off) && (32'(y) < y_off + v_res);
        loc.addr   = FB_ADDR_W'(17'((32'(y) - y_off) * h_res + 32'(x)));
        return loc;
    endfunction

endpackage

// File: rtl/fb_port_scheduler_if.sv
// Pixel, host-write and RAM-port signals of the frame-buffer scheduler.
interface fb_port_scheduler_if;
    import fb_pkg::*;

    logic [FB_COORD_W-1:0] i_x_in;
    logic [FB_COORD_W-1:0] i_y_in;
    logic                  pix_enable;
    logic                  i_wr_valid;
    logic                  o_wr_ready;
    logic [FB_ADDR_W-1:0]  i_wr_addr;
    logic [FB_DATA_W-1:0]  i_wr_data;
    logic                  o_mem_en;
    logic                  o_mem_we;
    logic [FB_ADDR_W-1:0]  o_mem_addr;
    logic [FB_DATA_W-1:0]  o_mem_din;
    logic [FB_DATA_W-1:0]  i_mem_dout;
    logic [7:0]            o_r_out;
    logic [7:0]            o_g_out;
    logic [7:0]            o_b_out;
    logic                  o_pix_valid;
    logic                  o_steal;

    modport slave (
        input  i_x_in, i_y_in, pix_enable, i_wr_valid, i_wr_addr, i_wr_data, i_mem_dout,
        output o_wr_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_din,
               o_r_out, o_g_out, o_b_out, o_pix_valid, o_steal
    );

    modport master (
        output i_x_in, i_y_in, pix_enable, i_wr_valid, i_wr_addr, i_wr_data, i_mem_dout,
        input  o_wr_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_din,
               o_r_out, o_g_out, o_b_out, o_pix_valid, o_steal
    );

endinterface

// File: rtl/fb_tag_delay.sv
// Resettable shift-register delay line of DEPTH stages.
module fb_tag_delay #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/fb_port_scheduler.sv
// Single owner of the frame-buffer RAM port: fixed-latency pixel reads with
// priority in the picture window, host writes guaranteed by a starvation counter.
module fb_port_scheduler
    import fb_pkg::*;
#(
    parameter int unsigned H_RES      = 320,
    parameter int unsigned V_RES      = 200,
    parameter int unsigned Y_OFF      = 40,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 15
) (
    input logic          clk,
    input logic          rst,
    fb_port_scheduler_if.slave bus
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TAG_W = $bits(fb_tag_t);

    generate
        if (H_RES * V_RES > 65536) begin : g_bad_geometry
            $error("fb_port_scheduler: H_RES*V_RES exceeds the 16-bit address space");
        end
        if (MEM_LAT < 1 || MEM_LAT > 2) begin : g_bad_lat
            $error("fb_port_scheduler: MEM_LAT must be 1 or 2");
        end
        if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve
            $error("fb_port_scheduler: STARVE_MAX must be 1..255");
        end
    endgenerate

    fb_loc_t              loc;
    logic                 rd_req;
    logic                 starved;
    logic                 wr_ready;
    logic                 rd_issue;
    logic                 wr_issue;
    fb_tag_t              tag_in;
    fb_tag_t              tag_out;
    logic [CNT_W-1:0]     starve_cnt;
    logic                 mem_en;
    logic                 mem_we;
    logic [FB_ADDR_W-1:0] mem_addr;
    logic [FB_DATA_W-1:0] mem_din;
    rgb888_t              pix_q;
    logic                 pix_valid;
    logic                 steal;

    // Arbitration: reads own the port in-window unless a write has waited too long.
    always_comb begin
        loc           = fb_addr(bus.i_x_in, bus.i_y_in, H_RES, V_RES, Y_OFF);
        rd_req        = bus.pix_enable && loc.in_win;
        starved       = (starve_cnt == CNT_W'(STARVE_MAX)) && bus.i_wr_valid;
        wr_ready      = !rd_req || starved;
        rd_issue      = rd_req && !starved;
        wr_issue      = bus.i_wr_valid && wr_ready;
        tag_in.valid  = bus.pix_enable;
        tag_in.in_win = rd_req;
        tag_in.stolen = rd_req && starved;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            mem_en <= rd_issue || wr_issue;
            mem_we <= wr_issue;
            if (rd_issue) begin
                mem_addr <= loc.addr;
            end else if (wr_issue) begin
                mem_addr <= bus.i_wr_addr;
                mem_din  <= bus.i_wr_data;
            end
        end
    end

    // Counts consecutive refused write cycles, saturating at the steal threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (bus.i_wr_valid && !wr_ready) begin
            if (starve_cnt != CNT_W'(STARVE_MAX)) starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Address register plus RAM latency; the output register below is the last stage.
    fb_tag_delay #(
        .DEPTH (MEM_LAT + 1),
        .WIDTH (TAG_W)
    ) u_tag_delay (
        .clk (clk),
        .rst (rst),
        .d   (tag_in),
        .q   (tag_out)
    );

    // A stolen slot repeats the previous pixel instead of showing stale RAM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q     <= '0;
            pix_valid <= 1'b0;
            steal     <= 1'b0;
        end else begin
            pix_valid <= tag_out.valid;
            steal     <= tag_out.stolen;
            if (!tag_out.in_win) begin
                pix_q <= '0;
            end else if (!tag_out.stolen) begin
                pix_q <= rgb888_t'(bus.i_mem_dout);
            end
        end
    end

    assign bus.o_wr_ready  = wr_ready;
    assign bus.o_mem_en    = mem_en;
    assign bus.o_mem_we    = mem_we;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_din   = mem_din;
    assign bus.o_r_out     = pix_q.r;
    assign bus.o_g_out     = pix_q.g;
    assign bus.o_b_out     = pix_q.b;
    assign bus.o_pix_valid = pix_valid;
    assign bus.o_steal     = steal;

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Directed plus random bench for fb_port_scheduler against a frame-level reference model.
module tb_fb_port_scheduler;

    typedef struct {
        logic        valid;
        logic [23:0] rgb;
        logic        steal;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fb_port_scheduler_if bus();

    fb_port_scheduler #(
        .H_RES(320), .V_RES(200), .Y_OFF(40), .MEM_LAT(1), .STARVE_MAX(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment RAM: one access per cycle, write-first, one-cycle read latency.
    logic [23:0] ram     [65536];
    logic [23:0] ref_mem [65536];
    always @(posedge clk) begin
        if (bus.o_mem_en) begin
            if (bus.o_mem_we) begin
                ram[bus.o_mem_addr] <= bus.o_mem_din;
                bus.i_mem_dout      <= bus.o_mem_din;
            end else begin
                bus.i_mem_dout <= ram[bus.o_mem_addr];
            end
        end
    end

    int          total = 0;
    int          bad   = 0;
    int          refused;
    logic [23:0] last_rgb;
    exp_t        expq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] rgb_obs();
        return {bus.o_r_out, bus.o_g_out, bus.o_b_out};
    endfunction

    task automatic model_reset();
        exp_t z;
        z.valid = 1'b0; z.rgb = 24'h0; z.steal = 1'b0;
        expq.delete();
        expq.push_back(z);
        expq.push_back(z);
        refused  = 0;
        last_rgb = 24'h0;
    endtask

    // One clock: drive inputs, check ready, predict, then check RAM port and pipeline output.
    task automatic step(input logic [11:0] x, input logic [11:0] y, input logic pe,
                        input logic wv, input logic [15:0] wa, input logic [23:0] wd,
                        output logic obs_rdy);
        exp_t        e;
        logic        win, starved, rdy, x_en, x_we;
        logic [15:0] x_addr;
        int unsigned a;
        bus.i_x_in = x; bus.i_y_in = y; bus.pix_enable = pe;
        bus.i_wr_valid = wv; bus.i_wr_addr = wa; bus.i_wr_data = wd;
        win     = pe && (x < 12'd320) && (y >= 12'd40) && (y < 12'd240);
        starved = (refused == 15) && wv;
        rdy     = !win || starved;
        #1;
        obs_rdy = bus.o_wr_ready;
        chk("wr_ready", 32'(bus.o_wr_ready), 32'(rdy));
        a = (32'(y) - 32'd40) * 32'd320 + 32'(x);
        e.valid = pe;
        e.steal = win && starved;
        if (!win)        e.rgb = 24'h0;
        else if (starved) e.rgb = last_rgb;
        else             e.rgb = ref_mem[16'(a)];
        last_rgb = e.rgb;
        expq.push_back(e);
        x_en = 1'b0; x_we = 1'b0; x_addr = 16'h0;
        if (win && !starved) begin
            x_en = 1'b1; x_addr = 16'(a);
        end else if (wv && rdy) begin
            x_en = 1'b1; x_we = 1'b1; x_addr = wa;
            ref_mem[wa] = wd;
        end
        refused = (wv && !rdy) ? ((refused < 15) ? refused + 1 : 15) : 0;
        @(posedge clk);
        #1;
        chk("mem_en", 32'(bus.o_mem_en), 32'(x_en));
        chk("mem_we", 32'(bus.o_mem_we), 32'(x_we));
        if (x_en) chk("mem_addr", 32'(bus.o_mem_addr), 32'(x_addr));
        if (x_we) chk("mem_din", 32'(bus.o_mem_din), 32'(wd));
        if (expq.size() >= 3) begin
            e = expq.pop_front();
            chk("pix_valid", 32'(bus.o_pix_valid), 32'(e.valid));
            chk("rgb", 32'(rgb_obs()), 32'(e.rgb));
            chk("steal", 32'(bus.o_steal), 32'(e.steal));
        end
    endtask

    task automatic px(input logic [11:0] x, input logic [11:0] y);
        logic r;
        step(x, y, 1'b1, 1'b0, 16'h0, 24'h0, r);
    endtask

    task automatic idle();
        logic r;
        step(12'h0, 12'h0, 1'b0, 1'b0, 16'h0, 24'h0, r);
    endtask

    logic [15:0] wr_a [100];
    logic [15:0] wa;
    logic [23:0] wd;
    logic        r;
    int          first;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 24'(i);
            ref_mem[i] = 24'(i);
        end
        bus.i_x_in = '0; bus.i_y_in = '0; bus.pix_enable = 1'b0;
        bus.i_wr_valid = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_mem_dout = '0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", 32'(bus.o_mem_en), 32'd0);
        chk("rst_mem_we", 32'(bus.o_mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.o_mem_addr), 32'd0);
        chk("rst_pix_valid", 32'(bus.o_pix_valid), 32'd0);
        chk("rst_rgb", 32'(rgb_obs()), 32'd0);
        chk("rst_steal", 32'(bus.o_steal), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Read alignment across the first picture line.
        for (int x = 0; x < 320; x++) px(12'(x), 12'd40);
        idle(); idle();

        // Window edges.
        px(12'd10, 12'd39);
        px(12'd320, 12'd40);
        px(12'd319, 12'd239);
        px(12'd0, 12'd240);
        step(12'd5, 12'd50, 1'b0, 1'b0, 16'h0, 24'h0, r);
        idle(); idle();

        // Back-to-back writes during blanking, then read them back through the window.
        for (int i = 0; i < 100; i++) begin
            wr_a[i] = 16'($urandom_range(320, 63999));
            step(12'h0, 12'h0, 1'b0, 1'b1, wr_a[i], 24'($urandom), r);
            chk("blank_ready", 32'(r), 32'd1);
        end
        for (int i = 0; i < 100; i++) px(12'(wr_a[i] % 16'd320), 12'(16'd40 + wr_a[i] / 16'd320));
        idle(); idle();

        // Write in blanking, then display the same pixel.
        step(12'h0, 12'h0, 1'b0, 1'b1, 16'd100, 24'hABCDEF, r);
        px(12'd100, 12'd40);
        idle(); idle();
        chk("wr_then_rd", 32'(rgb_obs()), 32'h00ABCDEF);

        // Starvation during a continuous in-window line.
        wa = 16'($urandom_range(0, 63999));
        wd = 24'($urandom);
        first = -1;
        for (int i = 0; i < 40; i++) begin
            step(12'(i), 12'd41, 1'b1, 1'b1, wa, wd, r);
            if (r) begin
                if (first < 0) first = i;
                wa = 16'($urandom_range(0, 63999));
                wd = 24'($urandom);
            end
        end
        chk("starve_first_ready", 32'(first), 32'd15);
        idle(); idle(); idle();

        // Asynchronous reset mid-frame with a write pending.
        for (int i = 0; i < 5; i++) step(12'(i + 50), 12'd60, 1'b1, 1'b1, 16'd6, 24'h123456, r);
        bus.pix_enable = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_mem_en", 32'(bus.o_mem_en), 32'd0);
        chk("arst_mem_we", 32'(bus.o_mem_we), 32'd0);
        chk("arst_pix_valid", 32'(bus.o_pix_valid), 32'd0);
        chk("arst_rgb", 32'(rgb_obs()), 32'd0);
        chk("arst_steal", 32'(bus.o_steal), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_no_write", 32'(bus.o_mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_wr_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        px(12'd6, 12'd40);
        idle(); idle();
        chk("arst_addr6_intact", 32'(rgb_obs()), 32'h00000006);

        // Random mix of pixels, blanking and host writes.
        wa = 16'($urandom);
        wd = 24'($urandom);
        for (int i = 0; i < 400; i++) begin
            logic pe, wv;
            pe = ($urandom_range(0, 3) != 0);
            wv = ($urandom_range(0, 1) != 0);
            step(12'($urandom_range(0, 330)), 12'($urandom_range(30, 250)), pe, wv, wa, wd, r);
            if (wv && r) begin
                wa = 16'($urandom);
                wd = 24'($urandom);
            end
        end
        idle(); idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
